// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: host pin-command front end for the UART core.
// Purpose : decodes strobed 7-bit pin commands into TX bytes, UART config and
//           baud prescaler words, plus a soft reset command.
// Latency : strobe edge is seen SYNC_STAGES+1 clocks after the pin rises;
//           effects appear on the clock edge ending that edge cycle.
// Backpressure: io_txValid holds the byte until io_txReady; a byte arriving
//           while one is still pending (and not accepted) is dropped and
//           io_overrun is set.
// Ports   : clk, reset (sync, active-high); io_in7 {payload[4:0], cmd[1:0]};
//           io_cmdStrobe (async); TX byte handshake io_txData/io_txValid/
//           io_txReady; io_prediv + io_predivLoad; io_config;
//           io_resetCommandStrobe; sticky io_overrun / io_cmdError.
// Option  : UART_CMD_SEQ_STATUS_EN adds io_status[7:0] =
//           {overrun, cmdError, txValid, pdState[1:0], lastCmd[1:0], edgeSeen}.
module uart_cmd_sequencer #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] PREDIV_RESET = 16'h0068,
  parameter logic [7:0]  CONFIG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  io_in7,
  input  logic        io_cmdStrobe,
  output logic [7:0]  io_txData,
  output logic        io_txValid,
  input  logic        io_txReady,
  output logic [15:0] io_prediv,
  output logic        io_predivLoad,
  output logic [7:0]  io_config,
  output logic        io_resetCommandStrobe,
  output logic        io_overrun,
  output logic        io_cmdError
`ifdef UART_CMD_SEQ_STATUS_EN
  ,
  output logic [7:0]  io_status
`endif
);

  typedef enum logic [1:0] {PD_IDLE, PD_N1, PD_N2, PD_N3} pd_state_e;

  localparam logic [1:0] CMD_DATA   = 2'd0;
  localparam logic [1:0] CMD_CONFIG = 2'd1;
  localparam logic [1:0] CMD_PREDIV = 2'd2;
  localparam logic [1:0] CMD_SPARE  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_last_q;
  logic                   strobe_edge;

  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic [15:0] prediv_q;
  logic [15:0] shadow_q;
  logic        pd_load_q;
  logic [7:0]  config_q;
  logic        rst_cmd_q;
  logic        overrun_q;
  logic        cmd_error_q;
  logic [3:0]  lo_nib_q;
  pd_state_e   pd_state_q;
  logic [1:0]  last_cmd_q;
  logic        edge_seen_q;

  logic [1:0] cmd;
  logic       sel;
  logic [3:0] nib;

  assign cmd = io_in7[1:0];
  assign sel = io_in7[6];
  assign nib = io_in7[5:2];

  // Chain and edge flop reset to 1 so a strobe held high through reset
  // cannot produce a rising edge once reset is released.
  assign strobe_edge = sync_q[SYNC_STAGES-1] & ~strobe_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '1;
      strobe_last_q <= 1'b1;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      prediv_q      <= PREDIV_RESET;
      shadow_q      <= 16'h0000;
      pd_load_q     <= 1'b0;
      config_q      <= CONFIG_RESET;
      rst_cmd_q     <= 1'b0;
      overrun_q     <= 1'b0;
      cmd_error_q   <= 1'b0;
      lo_nib_q      <= 4'h0;
      pd_state_q    <= PD_IDLE;
      last_cmd_q    <= 2'd0;
      edge_seen_q   <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], io_cmdStrobe};
      strobe_last_q <= sync_q[SYNC_STAGES-1];
      pd_load_q     <= 1'b0;
      rst_cmd_q     <= 1'b0;

      // Handshake first; a byte loaded below in the same cycle wins.
      if (tx_valid_q && io_txReady) tx_valid_q <= 1'b0;

      if (strobe_edge) begin
        last_cmd_q  <= cmd;
        edge_seen_q <= ~edge_seen_q;
        case (cmd)
          CMD_DATA: begin
            if (!sel) begin
              lo_nib_q <= nib;
            end else if (!tx_valid_q || io_txReady) begin
              tx_data_q  <= {nib, lo_nib_q};
              tx_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          CMD_CONFIG: begin
            if (sel && nib == 4'b1000) begin
              // Soft reset: restore defaults without a predivLoad pulse.
              rst_cmd_q   <= 1'b1;
              prediv_q    <= PREDIV_RESET;
              config_q    <= CONFIG_RESET;
              tx_valid_q  <= 1'b0;
              overrun_q   <= 1'b0;
              cmd_error_q <= 1'b0;
              lo_nib_q    <= 4'h0;
              pd_state_q  <= PD_IDLE;
            end else if (!sel) begin
              config_q[3:0] <= nib;
            end else begin
              config_q[7:4] <= nib;
            end
          end
          CMD_PREDIV: begin
            // sel=1 always restarts the word with its most significant nibble.
            if (sel) begin
              shadow_q[15:12] <= nib;
              pd_state_q      <= PD_N1;
            end else begin
              case (pd_state_q)
                PD_IDLE: cmd_error_q <= 1'b1;
                PD_N1: begin
                  shadow_q[11:8] <= nib;
                  pd_state_q     <= PD_N2;
                end
                PD_N2: begin
                  shadow_q[7:4] <= nib;
                  pd_state_q    <= PD_N3;
                end
                PD_N3: begin
                  shadow_q[3:0] <= nib;
                  prediv_q      <= {shadow_q[15:4], nib};
                  pd_load_q     <= 1'b1;
                  pd_state_q    <= PD_IDLE;
                end
                default: pd_state_q <= PD_IDLE;
              endcase
            end
          end
          CMD_SPARE: cmd_error_q <= 1'b1;
          default: cmd_error_q <= 1'b1;
        endcase
      end
    end
  end

  assign io_txData             = tx_data_q;
  assign io_txValid            = tx_valid_q;
  assign io_prediv             = prediv_q;
  assign io_predivLoad         = pd_load_q;
  assign io_config             = config_q;
  assign io_resetCommandStrobe = rst_cmd_q;
  assign io_overrun            = overrun_q;
  assign io_cmdError           = cmd_error_q;

`ifdef UART_CMD_SEQ_STATUS_EN
  assign io_status = {overrun_q, cmd_error_q, tx_valid_q, pd_state_q,
                      last_cmd_q, edge_seen_q};
`endif

endmodule
